smi_rx_arbiter: RTL and testbench

Sits between the two per-channel RX sample FIFOs (ch0 = sub-GHz modem, ch1 = 2.4 GHz modem) and the SMI controller's single FIFO-pull interface. Selects which channel feeds the SMI stream according to a configured mode (fixed, round-robin burst, or ch0-priority). Presents one registered 32-bit word with an empty flag and a one-cycle pull handshake. Reports which channel the presented word came from.

---
 rtl/smi_rx_arb_pkg.sv | 16 +
 rtl/smi_rx_arbiter_if.sv | 17 +
 rtl/smi_rx_arb_select.sv | 25 ++
 rtl/smi_rx_arbiter.sv | 90 +++++++++
 tb/tb_smi_rx_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/smi_rx_arb_pkg.sv
// smi_rx_arb_pkg: mode encodings, FSM states and channel IDs shared by the SMI RX arbiter.
package smi_rx_arb_pkg;
   typedef logic [1:0] state_t;
   localparam logic [1:0] MODE_FIXED = 2'b00;
   localparam logic [1:0] MODE_RR    = 2'b01;
   localparam logic [1:0] MODE_PRIO0 = 2'b10;
   localparam state_t ST_SELECT  = 2'd0;
   localparam state_t ST_FETCH   = 2'd1;
   localparam state_t ST_CAPTURE = 2'd2;
   localparam state_t ST_VALID   = 2'd3;
   localparam logic CH0 = 1'b0;
   localparam logic CH1 = 1'b1;
   function automatic logic is_shared(input logic [1:0] mode);
      return mode == MODE_RR || mode == MODE_PRIO0;
   endfunction
endpackage

// File: rtl/smi_rx_arbiter_if.sv
// smi_rx_arbiter_if: upstream FIFO pull ports of both channels plus the SMI-side pull stream.
interface smi_rx_arbiter_if #(parameter int DATA_W = 32);
   logic              o_ch0_pull, i_ch0_empty, i_ch0_full;
   logic [DATA_W-1:0] i_ch0_data;
   logic              o_ch1_pull, i_ch1_empty, i_ch1_full;
   logic [DATA_W-1:0] i_ch1_data;
   logic              i_fifo_pull, o_fifo_empty, o_fifo_full, o_channel;
   logic [DATA_W-1:0] o_fifo_pulled_data;
   modport slave (
      input  i_ch0_data, i_ch0_empty, i_ch0_full, i_ch1_data, i_ch1_empty, i_ch1_full, i_fifo_pull,
      output o_ch0_pull, o_ch1_pull, o_fifo_pulled_data, o_fifo_empty, o_fifo_full, o_channel
   );
   modport master (
      output i_ch0_data, i_ch0_empty, i_ch0_full, i_ch1_data, i_ch1_empty, i_ch1_full, i_fifo_pull,
      input  o_ch0_pull, o_ch1_pull, o_fifo_pulled_data, o_fifo_empty, o_fifo_full, o_channel
   );
endinterface

// File: rtl/smi_rx_arb_select.sv
// smi_rx_arb_select: combinational channel choice from mode, FIFO empties, last-served channel and burst count.
module smi_rx_arb_select
   import smi_rx_arb_pkg::*;
#(
   parameter int BURST_LEN = 16
) (
   input  logic [1:0] mode_i,
   input  logic       channel_sel_i,
   input  logic [1:0] empty_i,
   input  logic       cur_ch_i,
   input  logic [7:0] burst_i,
   output logic       ch_o,
   output logic       ok_o,
   output logic       switch_o
);
   logic keep, rr_ch;
   // A zero burst count means no burst has started yet, so RR moves off the reset channel.
   assign keep  = burst_i != '0 && burst_i < 8'(BURST_LEN) && !empty_i[cur_ch_i];
   assign rr_ch = (keep || empty_i[~cur_ch_i]) ? cur_ch_i : ~cur_ch_i;
   always_comb begin
      ch_o     = mode_i == MODE_RR ? rr_ch : mode_i == MODE_PRIO0 ? (empty_i[0] ? CH1 : CH0) : channel_sel_i;
      ok_o     = !empty_i[ch_o];
      switch_o = mode_i == MODE_RR && ch_o != cur_ch_i;
   end
endmodule

// File: rtl/smi_rx_arbiter.sv
// smi_rx_arbiter: merges two RX sample FIFOs into one registered SMI pull stream.
// Define SMI_RX_ARB_OVF_CNT_EN to add per-channel saturating overflow counters.
module smi_rx_arbiter
   import smi_rx_arb_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 16
) (
   input  logic              i_sys_clk,
   input  logic              i_rst,
   input  logic [1:0]        i_mode,
   input  logic              i_channel_sel,
   smi_rx_arbiter_if.slave   bus
`ifdef SMI_RX_ARB_OVF_CNT_EN
   ,
   output logic [15:0]       o_ovf_cnt0,
   output logic [15:0]       o_ovf_cnt1
`endif
);
   state_t            state_q, state_d;
   logic              ch_q, last_q, channel_q, empty_q;
   logic [7:0]        burst_q;
   logic [DATA_W-1:0] data_q;
   logic              sel_ch, sel_ok, sel_sw;
   smi_rx_arb_select #(.BURST_LEN(BURST_LEN)) u_select (
      .mode_i        (i_mode),
      .channel_sel_i (i_channel_sel),
      .empty_i       ({bus.i_ch1_empty, bus.i_ch0_empty}),
      .cur_ch_i      (last_q),
      .burst_i       (burst_q),
      .ch_o          (sel_ch),
      .ok_o          (sel_ok),
      .switch_o      (sel_sw)
   );
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_SELECT:  state_d = sel_ok ? ST_FETCH : ST_SELECT;
         ST_FETCH:   state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = ST_VALID;
         default:    state_d = bus.i_fifo_pull ? ST_SELECT : ST_VALID;
      endcase
   end
   always_ff @(posedge i_sys_clk) begin
      if (i_rst) begin
         state_q   <= ST_SELECT;
         ch_q      <= CH0;
         last_q    <= CH1;
         burst_q   <= '0;
         data_q    <= '0;
         empty_q   <= 1'b1;
         channel_q <= CH0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_SELECT && sel_ok) begin
            ch_q <= sel_ch;
            if (sel_sw) burst_q <= '0;
         end
         if (state_q == ST_CAPTURE) begin
            data_q    <= ch_q ? bus.i_ch1_data : bus.i_ch0_data;
            channel_q <= ch_q;
            last_q    <= ch_q;
            empty_q   <= 1'b0;
            burst_q   <= burst_q == 8'(BURST_LEN) ? burst_q : burst_q + 8'd1;
         end
         if (state_q == ST_VALID && bus.i_fifo_pull) empty_q <= 1'b1;
      end
   end
   assign bus.o_ch0_pull         = state_q == ST_FETCH && ch_q == CH0;
   assign bus.o_ch1_pull         = state_q == ST_FETCH && ch_q == CH1;
   assign bus.o_fifo_pulled_data = data_q;
   assign bus.o_fifo_empty       = empty_q;
   assign bus.o_channel          = channel_q;
   assign bus.o_fifo_full        = is_shared(i_mode) ? (bus.i_ch0_full | bus.i_ch1_full)
                                 : (i_channel_sel ? bus.i_ch1_full : bus.i_ch0_full);
`ifdef SMI_RX_ARB_OVF_CNT_EN
   logic [15:0] ovf0_q, ovf1_q;
   always_ff @(posedge i_sys_clk) begin
      if (i_rst) begin
         ovf0_q <= '0;
         ovf1_q <= '0;
      end else begin
         if (bus.i_ch0_full && !bus.o_ch0_pull && ovf0_q != 16'hFFFF) ovf0_q <= ovf0_q + 16'd1;
         if (bus.i_ch1_full && !bus.o_ch1_pull && ovf1_q != 16'hFFFF) ovf1_q <= ovf1_q + 16'd1;
      end
   end
   assign o_ovf_cnt0 = ovf0_q;
   assign o_ovf_cnt1 = ovf1_q;
`endif
endmodule

// File: tb/tb_smi_rx_arbiter.sv
// tb_smi_rx_arbiter: directed bench with upstream FIFO models and an in-flight word scoreboard.
module tb_smi_rx_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] mode = 2'b00;
   logic       sel = 1'b1;
   int         checks = 0, fails = 0;
   int         pulls0 = 0, pulls1 = 0, since = 0;
   logic [31:0] q0[$], q1[$], e0[$], e1[$];
   int          exp_ch[$];
   logic [31:0] infl_d;
   logic        infl_c, infl_v = 1'b0, prev_empty = 1'b1;
   smi_rx_arbiter_if #(.DATA_W(32)) bus ();
`ifdef SMI_RX_ARB_OVF_CNT_EN
   logic [15:0] ovf0, ovf1;
`endif
   smi_rx_arbiter #(.DATA_W(32), .BURST_LEN(4)) dut (
      .i_sys_clk     (clk),
      .i_rst         (rst),
      .i_mode        (mode),
      .i_channel_sel (sel),
      .bus           (bus)
`ifdef SMI_RX_ARB_OVF_CNT_EN
      ,
      .o_ovf_cnt0    (ovf0),
      .o_ovf_cnt1    (ovf1)
`endif
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask
   function automatic logic exp_full();
      return (mode == 2'b01 || mode == 2'b10) ? (bus.i_ch0_full | bus.i_ch1_full)
           : (sel ? bus.i_ch1_full : bus.i_ch0_full);
   endfunction
   // Upstream FIFO models: read data appears one cycle after a pull.
   always @(posedge clk) begin
      if (bus.o_ch0_pull && q0.size() > 0) bus.i_ch0_data <= q0.pop_front();
      if (bus.o_ch1_pull && q1.size() > 0) bus.i_ch1_data <= q1.pop_front();
      bus.i_ch0_empty <= q0.size() == 0;
      bus.i_ch1_empty <= q1.size() == 0;
   end
   task automatic push(input int c, input logic [31:0] w);
      if (c == 0) begin q0.push_back(w); e0.push_back(w); end
      else begin q1.push_back(w); e1.push_back(w); end
   endtask
   // Scoreboard: each presented word must be the one most recently pulled upstream.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         infl_v = 1'b0;
         since = 0;
         prev_empty = 1'b1;
      end else begin
         chk("one_pull", 32'(bus.o_ch0_pull & bus.o_ch1_pull), 0);
         chk("pull0_nonempty", 32'(bus.o_ch0_pull & bus.i_ch0_empty), 0);
         chk("pull1_nonempty", 32'(bus.o_ch1_pull & bus.i_ch1_empty), 0);
         chk("fifo_full", 32'(bus.o_fifo_full), 32'(exp_full()));
         if (bus.o_ch0_pull) begin
            pulls0++; since++; infl_v = 1'b1; infl_c = 1'b0;
            infl_d = e0.size() > 0 ? e0.pop_front() : 32'hDEAD_DEAD;
         end
         if (bus.o_ch1_pull) begin
            pulls1++; since++; infl_v = 1'b1; infl_c = 1'b1;
            infl_d = e1.size() > 0 ? e1.pop_front() : 32'hDEAD_DEAD;
         end
         if (prev_empty && !bus.o_fifo_empty) begin
            chk("pulls_per_word", since, 1);
            chk("word_inflight", 32'(infl_v), 1);
            chk("word_chan", 32'(bus.o_channel), 32'(infl_c));
            chk("word_data", bus.o_fifo_pulled_data, infl_d);
            chk("chan_seq", 32'(bus.o_channel), exp_ch.size() > 0 ? 32'(exp_ch.pop_front()) : 32'd2);
            since = 0;
            infl_v = 1'b0;
         end
         prev_empty = bus.o_fifo_empty;
      end
   end
   task automatic wait_word(output bit ok);
      int t = 0;
      while (bus.o_fifo_empty && t < 50) begin @(negedge clk); t++; end
      ok = t < 50;
      if (!ok) chk("word_timeout", 1, 0);
   endtask
   task automatic consume(input int n);
      bit ok;
      for (int i = 0; i < n; i++) begin
         wait_word(ok);
         if (!ok) return;
         bus.i_fifo_pull = 1'b1;
         @(negedge clk);
         bus.i_fifo_pull = 1'b0;
      end
   endtask
   task automatic do_reset(input logic [1:0] m, input logic s);
      rst = 1'b1;
      mode = m;
      sel = s;
      q0.delete(); q1.delete(); e0.delete(); e1.delete(); exp_ch.delete();
      repeat (2) @(negedge clk);
   endtask
   initial begin
      bit ok;
      bus.i_fifo_pull = 1'b0;
      bus.i_ch0_full = 1'b0;
      bus.i_ch1_full = 1'b0;
      bus.i_ch0_data = '0;
      bus.i_ch1_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_empty", 32'(bus.o_fifo_empty), 1);
      chk("rst_data", bus.o_fifo_pulled_data, 0);
      chk("rst_chan", 32'(bus.o_channel), 0);
      chk("rst_pulls", 32'(bus.o_ch0_pull | bus.o_ch1_pull), 0);
      mode = 2'b11; sel = 1'b0; bus.i_ch0_full = 1'b1; #1;
      chk("full_mode3_sel0", 32'(bus.o_fifo_full), 1);
      sel = 1'b1; #1;
      chk("full_fixed_other", 32'(bus.o_fifo_full), 0);
      mode = 2'b01; #1;
      chk("full_rr_or", 32'(bus.o_fifo_full), 1);
      bus.i_ch0_full = 1'b0;
      // FIXED on ch1 with ch0 also holding words
      do_reset(2'b00, 1'b1);
      for (int i = 1; i <= 3; i++) begin push(1, 32'hA000_0000 + 32'(i)); exp_ch.push_back(1); end
      push(0, 32'hB000_0001); push(0, 32'hB000_0002);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("latency_2", 32'(bus.o_fifo_empty), 1);
      @(negedge clk);
      chk("latency_3", 32'(bus.o_fifo_empty), 0);
      chk("first_data", bus.o_fifo_pulled_data, 32'hA000_0001);
      chk("first_chan", 32'(bus.o_channel), 1);
      consume(3);
      repeat (4) @(negedge clk);
      chk("fixed_no_ch0_pull", pulls0, 0);
      chk("fixed_ch1_pulls", pulls1, 3);
      for (int i = 0; i < 3; i++) begin
         bus.i_fifo_pull = 1'b1; @(negedge clk);
         bus.i_fifo_pull = 1'b0; @(negedge clk);
      end
      chk("ignored_pull_empty", 32'(bus.o_fifo_empty), 1);
      chk("ignored_pull_ch0", pulls0, 0);
      chk("ignored_pull_ch1", pulls1, 3);
      push(1, 32'hA000_0004); exp_ch.push_back(1);
      consume(1);
      chk("one_pull_per_word", pulls1, 4);
      // ROUND_ROBIN, burst of 4
      do_reset(2'b01, 1'b0);
      for (int i = 1; i <= 10; i++) begin push(0, 32'hB000_0100 + 32'(i)); push(1, 32'hA000_0100 + 32'(i)); end
      foreach (exp_ch[i]) ;
      for (int i = 0; i < 20; i++) exp_ch.push_back(i < 16 ? (i / 4) % 2 : (i < 18 ? 0 : 1));
      @(negedge clk);
      rst = 1'b0;
      consume(20);
      chk("rr_pulls0", pulls0, 10);
      chk("rr_pulls1", pulls1, 14);
      for (int i = 1; i <= 6; i++) push(0, 32'hB000_0200 + 32'(i));
      push(1, 32'hA000_0201); push(1, 32'hA000_0202);
      exp_ch.push_back(1); exp_ch.push_back(1);
      for (int i = 0; i < 6; i++) exp_ch.push_back(0);
      consume(8);
      chk("rr_drain_pulls0", pulls0, 16);
      // PRIORITY_CH0 with ch0 arriving mid-stream
      do_reset(2'b10, 1'b0);
      push(1, 32'hA000_0301); push(1, 32'hA000_0302);
      exp_ch.push_back(1); exp_ch.push_back(0); exp_ch.push_back(1);
      @(negedge clk);
      rst = 1'b0;
      wait_word(ok);
      push(0, 32'hB000_0301);
      consume(3);
      chk("prio_words_left", exp_ch.size(), 0);
      // Reset while a fetched word is being captured
      do_reset(2'b00, 1'b0);
      push(0, 32'hB000_0401); push(0, 32'hB000_0402);
      exp_ch.push_back(0);
      @(negedge clk);
      rst = 1'b0;
      for (int t = 0; t < 20 && !bus.o_ch0_pull; t++) @(negedge clk);
      chk("capture_reached", 32'(bus.o_ch0_pull), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_cap_empty", 32'(bus.o_fifo_empty), 1);
      chk("rst_cap_data", bus.o_fifo_pulled_data, 0);
      chk("rst_cap_chan", 32'(bus.o_channel), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("after_rst_data", bus.o_fifo_pulled_data, 32'hB000_0402);
      consume(1);
`ifdef SMI_RX_ARB_OVF_CNT_EN
      do_reset(2'b00, 1'b0);
      bus.i_ch0_full = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("ovf0_5", 32'(ovf0), 5);
      repeat (70000) @(negedge clk);
      chk("ovf0_sat", 32'(ovf0), 32'hFFFF);
      chk("ovf1_zero", 32'(ovf1), 0);
      bus.i_ch0_full = 1'b0;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
